// File: rtl/window3x3_stream_if.sv
// Raster pixel input and 3x3 window output bundle for window3x3_stream.
// The design attaches through the slave modport; the driver or bench attaches through master.
interface window3x3_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_sof;
  logic [DATA_WIDTH-1:0] in_data;

  logic                  out_valid;
  logic                  out_sof;
  logic                  out_eol;
  logic [DATA_WIDTH-1:0] w00, w01, w02;
  logic [DATA_WIDTH-1:0] w10, w11, w12;
  logic [DATA_WIDTH-1:0] w20, w21, w22;
  logic                  frame_done;
  logic                  sof_err;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, out_sof, out_eol,
    input  w00, w01, w02, w10, w11, w12, w20, w21, w22,
    input  frame_done, sof_err
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, out_sof, out_eol,
    output w00, w01, w02, w10, w11, w12, w20, w21, w22,
    output frame_done, sof_err
  );
endinterface

// File: rtl/window3x3_stream.sv
// Streaming 3x3 neighbourhood extractor: two line buffers plus a 3x3 column shifter,
// emitting one registered window per interior pixel of a raster frame.
module window3x3_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 176,
  parameter int unsigned IMG_HEIGHT = 176
) (
  input logic              pclk,
  input logic              reset,
  window3x3_stream_if.slave bus
);
  localparam int unsigned XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  // Frame position
  logic [XW-1:0] x_q, x_d, pos_x;
  logic [YW-1:0] y_q, y_d, pos_y;
  logic          pix_acc;

  // Line y-1 and line y-2 storage (not reset)
  logic [DATA_WIDTH-1:0] lb1_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_rd, lb2_rd;

  // [row][col] with row 0 = oldest line and col 0 = oldest column
  logic [2:0][2:0][DATA_WIDTH-1:0] col_q, col_d;
  logic [2:0][2:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [2:0][DATA_WIDTH-1:0]      new_col;

  logic valid_q, valid_d;
  logic sof_q,   sof_d;
  logic eol_q,   eol_d;
  logic done_q,  done_d;
  logic err_q,   err_d;

  // Pixels presented while reset is low are dropped; in_sof forces position (0,0).
  always_comb begin : position_select
    pix_acc = bus.in_valid & reset;
    pos_x   = bus.in_sof ? '0 : x_q;
    pos_y   = bus.in_sof ? '0 : y_q;
  end

  assign lb1_rd = lb1_mem[pos_x];
  assign lb2_rd = lb2_mem[pos_x];

  always_comb begin : column_build
    new_col    = '0;
    new_col[0] = lb2_rd;
    new_col[1] = lb1_rd;
    new_col[2] = bus.in_data;
  end

  always_comb begin : next_state
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    win_d   = win_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eol_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (pix_acc) begin
      err_d  = bus.in_sof && ((x_q != '0) || (y_q != '0));
      done_d = (pos_x == X_LAST) && (pos_y == Y_LAST);

      if (pos_x == X_LAST) begin
        x_d = '0;
        y_d = (pos_y == Y_LAST) ? '0 : pos_y + YW'(1);
      end else begin
        x_d = pos_x + XW'(1);
        y_d = pos_y;
      end

      for (int r = 0; r < 3; r++) begin
        col_d[r][0] = col_q[r][1];
        col_d[r][1] = col_q[r][2];
        col_d[r][2] = new_col[r];
      end

      // Interior pixels only: rows y-2..y all belong to the current frame.
      if ((pos_x >= X_TWO) && (pos_y >= Y_TWO)) begin
        win_d   = col_d;
        valid_d = 1'b1;
        sof_d   = (pos_x == X_TWO) && (pos_y == Y_TWO);
        eol_d   = (pos_x == X_LAST);
      end
    end
  end

  always_ff @(posedge pclk) begin : state_reg
    if (!reset) begin
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Read-before-write: the nonblocking write lands after this cycle's read.
  always_ff @(posedge pclk) begin : line_buffers
    if (pix_acc) begin
      lb1_mem[pos_x] <= bus.in_data;
      lb2_mem[pos_x] <= lb1_rd;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_sof    = sof_q;
  assign bus.out_eol    = eol_q;
  assign bus.frame_done = done_q;
  assign bus.sof_err    = err_q;

  assign bus.w00 = win_q[0][0];
  assign bus.w01 = win_q[0][1];
  assign bus.w02 = win_q[0][2];
  assign bus.w10 = win_q[1][0];
  assign bus.w11 = win_q[1][1];
  assign bus.w12 = win_q[1][2];
  assign bus.w20 = win_q[2][0];
  assign bus.w21 = win_q[2][1];
  assign bus.w22 = win_q[2][2];

endmodule

// File: tb/tb_window3x3_stream.sv
// Directed bench for window3x3_stream: a 5x4 8-bit instance and a 3x3 12-bit instance.
module tb_window3x3_stream;
  localparam int AW = 5;
  localparam int AH = 4;

  logic pclk = 1'b0;
  logic reset;
  always #5 pclk = ~pclk;

  window3x3_stream_if #(.DATA_WIDTH(8))  a_if ();
  window3x3_stream_if #(.DATA_WIDTH(12)) b_if ();

  window3x3_stream #(.DATA_WIDTH(8), .IMG_WIDTH(AW), .IMG_HEIGHT(AH)) u_a (
    .pclk (pclk),
    .reset(reset),
    .bus  (a_if)
  );

  window3x3_stream #(.DATA_WIDTH(12), .IMG_WIDTH(3), .IMG_HEIGHT(3)) u_b (
    .pclk (pclk),
    .reset(reset),
    .bus  (b_if)
  );

  int checks   = 0;
  int failures = 0;
  int n_win    = 0;
  int n_done   = 0;
  int n_err    = 0;
  logic [71:0] exp_win_a;
  logic [71:0] first_q [$];
  logic [7:0]  eol_q [$];
  logic [71:0] tmp;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] taps_a();
    return {a_if.w00, a_if.w01, a_if.w02, a_if.w10, a_if.w11, a_if.w12,
            a_if.w20, a_if.w21, a_if.w22};
  endfunction

  function automatic logic [107:0] taps_b();
    return {b_if.w00, b_if.w01, b_if.w02, b_if.w10, b_if.w11, b_if.w12,
            b_if.w20, b_if.w21, b_if.w22};
  endfunction

  // Window whose newest pixel is (x,y), pixel value = base + y*16 + x.
  function automatic logic [71:0] win_a(input int x, input int y, input int base);
    logic [71:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v = {v[63:0], 8'(base + (y - 2 + r) * 16 + (x - 2 + c))};
    return v;
  endfunction

  // One accepted pixel at frame position (x,y); checks the registered result.
  task automatic px(input int x, input int y, input int base, input bit sof, input bit err);
    bit exp_v;
    a_if.in_valid = 1'b1;
    a_if.in_sof   = sof;
    a_if.in_data  = 8'(base + y * 16 + x);
    @(posedge pclk); #1;
    exp_v = (x >= 2) && (y >= 2);
    if (exp_v) exp_win_a = win_a(x, y, base);
    check("a_valid", 128'(a_if.out_valid), 128'(exp_v));
    check("a_sof",   128'(a_if.out_sof),   128'(exp_v && x == 2 && y == 2));
    check("a_eol",   128'(a_if.out_eol),   128'(exp_v && x == AW - 1));
    check("a_taps",  128'(taps_a()),       128'(exp_win_a));
    check("a_done",  128'(a_if.frame_done), 128'(x == AW - 1 && y == AH - 1));
    check("a_err",   128'(a_if.sof_err),   128'(err));
    if (a_if.out_valid) n_win++;
    if (a_if.frame_done) n_done++;
    if (a_if.sof_err) n_err++;
    if (a_if.out_valid && a_if.out_sof) first_q.push_back(taps_a());
    if (a_if.out_valid && a_if.out_eol) eol_q.push_back(a_if.w22);
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) begin
      a_if.in_valid = 1'b0;
      a_if.in_sof   = 1'b0;
      a_if.in_data  = 8'hEE;
      @(posedge pclk); #1;
      check("a_idle_valid", 128'(a_if.out_valid),  128'(0));
      check("a_idle_sof",   128'(a_if.out_sof),    128'(0));
      check("a_idle_eol",   128'(a_if.out_eol),    128'(0));
      check("a_idle_taps",  128'(taps_a()),        128'(exp_win_a));
      check("a_idle_done",  128'(a_if.frame_done), 128'(0));
    end
  endtask

  task automatic frame_a(input int base, input bit gaps);
    n_win = 0;
    for (int y = 0; y < AH; y++)
      for (int x = 0; x < AW; x++) begin
        px(x, y, base, (x == 0 && y == 0), 1'b0);
        if (gaps) idle_a(1);
      end
    check("a_nwin", 128'(n_win), 128'(6));
  endtask

  initial begin
    // Reset with traffic present: must be ignored
    reset = 1'b0;
    a_if.in_valid = 1'b1; a_if.in_sof = 1'b1; a_if.in_data = 8'h55;
    b_if.in_valid = 1'b0; b_if.in_sof = 1'b0; b_if.in_data = '0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_valid", 128'(a_if.out_valid),  128'(0));
    check("rst_sof",   128'(a_if.out_sof),    128'(0));
    check("rst_eol",   128'(a_if.out_eol),    128'(0));
    check("rst_done",  128'(a_if.frame_done), 128'(0));
    check("rst_err",   128'(a_if.sof_err),    128'(0));
    check("rst_taps",  128'(taps_a()),        128'(0));
    check("rst_b_valid", 128'(b_if.out_valid), 128'(0));
    check("rst_b_taps",  128'(taps_b()),       128'(0));
    reset = 1'b1;
    exp_win_a = '0;

    // Single frame, back-to-back pixels
    first_q.delete(); eol_q.delete();
    frame_a(0, 1'b0);
    check("f1_nsof", 128'(first_q.size()), 128'(1));
    tmp = first_q[0];
    check("f1_w00", 128'(tmp[71:64]), 128'(8'h00));
    check("f1_w11", 128'(tmp[39:32]), 128'(8'h11));
    check("f1_w22", 128'(tmp[7:0]),   128'(8'h22));
    check("f1_neol", 128'(eol_q.size()), 128'(2));
    check("f1_eol0", 128'(eol_q[0]), 128'(8'h24));
    check("f1_eol1", 128'(eol_q[1]), 128'(8'h34));

    // Same frame with an idle cycle after every pixel
    frame_a(0, 1'b1);

    // Two consecutive frames, second offset by 0x80
    n_done = 0; first_q.delete();
    frame_a(0, 1'b0);
    frame_a(8'h80, 1'b0);
    check("ff_ndone", 128'(n_done), 128'(2));
    check("ff_nsof", 128'(first_q.size()), 128'(2));
    tmp = first_q[1];
    check("ff_w00", 128'(tmp[71:64]), 128'(8'h80));

    // in_sof injected where (3,2) was expected
    n_err = 0;
    for (int p = 0; p < 13; p++) px(p % AW, p / AW, 0, (p == 0), 1'b0);
    first_q.delete();
    px(0, 0, 8'h40, 1'b1, 1'b1);
    for (int p = 1; p < AW * AH; p++) px(p % AW, p / AW, 8'h40, 1'b0, 1'b0);
    check("se_nerr", 128'(n_err), 128'(1));
    check("se_nsof", 128'(first_q.size()), 128'(1));
    tmp = first_q[0];
    check("se_w00", 128'(tmp[71:64]), 128'(8'h40));

    // One reset cycle where (2,3) was expected, restart without in_sof
    for (int p = 0; p < 17; p++) px(p % AW, p / AW, 0, (p == 0), 1'b0);
    reset = 1'b0;
    a_if.in_valid = 1'b1; a_if.in_sof = 1'b0; a_if.in_data = 8'h77;
    @(posedge pclk); #1;
    check("mr_valid", 128'(a_if.out_valid),  128'(0));
    check("mr_sof",   128'(a_if.out_sof),    128'(0));
    check("mr_eol",   128'(a_if.out_eol),    128'(0));
    check("mr_done",  128'(a_if.frame_done), 128'(0));
    check("mr_err",   128'(a_if.sof_err),    128'(0));
    check("mr_taps",  128'(taps_a()),        128'(0));
    reset = 1'b1;
    exp_win_a = '0;
    first_q.delete();
    for (int p = 0; p < AW * AH; p++) px(p % AW, p / AW, 8'h60, 1'b0, 1'b0);
    check("mr_nsof", 128'(first_q.size()), 128'(1));
    tmp = first_q[0];
    check("mr_centre", 128'(tmp[39:32]), 128'(8'h71));
    a_if.in_valid = 1'b0; a_if.in_sof = 1'b0;

    // 3x3 frame with 12-bit pixels: one window carrying both sof and eol
    for (int p = 0; p < 9; p++) begin
      b_if.in_valid = 1'b1;
      b_if.in_sof   = (p == 0);
      b_if.in_data  = 12'(12'hA00 + (p / 3) * 16 + (p % 3));
      @(posedge pclk); #1;
      check("b_valid", 128'(b_if.out_valid),  128'(p == 8));
      check("b_sof",   128'(b_if.out_sof),    128'(p == 8));
      check("b_eol",   128'(b_if.out_eol),    128'(p == 8));
      check("b_done",  128'(b_if.frame_done), 128'(p == 8));
    end
    check("b_taps", 128'(taps_b()), 128'(108'hA00A01A02A10A11A12A20A21A22));
    b_if.in_valid = 1'b0; b_if.in_sof = 1'b0;
    @(posedge pclk); #1;
    check("b_idle_valid", 128'(b_if.out_valid),  128'(0));
    check("b_idle_done",  128'(b_if.frame_done), 128'(0));
    check("b_idle_taps",  128'(taps_b()), 128'(108'hA00A01A02A10A11A12A20A21A22));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window3x3_stream.md
WINDOW3X3_STREAM -- requirements
Module: window3x3_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width in bits; legal range 1..16.
REQ-002 Parameter IMG_WIDTH, default 176: pixels per line; legal range 3..1024.
REQ-003 Parameter IMG_HEIGHT, default 176: lines per frame; legal range 3..1024.
REQ-004 pclk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the pclk rising edge.
REQ-006 in_valid  input  1  in_data is accepted this cycle; there is no backpressure.
REQ-007 in_sof  input  1  qualified by in_valid; marks the first pixel of a frame.
REQ-008 in_data  input  DATA_WIDTH  raster-order pixel.
REQ-009 out_valid  output  1  the window outputs hold a new 3x3 window.
REQ-010 out_sof  output  1  marks the first window of a frame.
REQ-011 out_eol  output  1  marks the last window of a line.
REQ-012 w00..w22  output  DATA_WIDTH each  nine taps, row-major; w00 is top-left (oldest line, oldest column); w22 is the newest pixel.
REQ-013 frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.
REQ-014 sof_err  output  1  one-cycle pulse when in_sof arrives while the position is not (0,0).

Function
REQ-015 The block SHALL keep column counter x (0..IMG_WIDTH-1) and line counter y (0..IMG_HEIGHT-1); both advance only on accepted pixels.
REQ-016 On an accepted pixel, x SHALL increment; at IMG_WIDTH-1, x SHALL wrap to 0 and y SHALL increment.
REQ-017 At (IMG_WIDTH-1, IMG_HEIGHT-1), x and y SHALL both wrap to 0, and frame_done SHALL pulse on the next cycle.
REQ-018 An accepted pixel with in_sof=1 SHALL be treated as position (0,0) regardless of the counters; subsequent pixels continue from (1,0).
REQ-019 If that in_sof pixel arrives while the counters are not at (0,0), sof_err SHALL pulse on the next cycle; the frame is resynchronised and no window is emitted for the aborted frame after that point.
REQ-020 Two line buffers, each IMG_WIDTH deep, SHALL hold lines y-1 and y-2; each is read and written at address x on the same accepted cycle, using read-before-write.
REQ-021 The block SHALL keep a three-column shift register per row; it shifts only on accepted pixels, with new column = {line y-2, line y-1, in_data}.
REQ-022 A window SHALL be emitted only when the accepted pixel has x>=2 and y>=2; the window covers lines y-2..y and columns x-2..x, centre (x-1, y-1).
REQ-023 Windows per frame SHALL number (IMG_WIDTH-2)*(IMG_HEIGHT-2); no border padding.
REQ-024 Output latency SHALL be 1 cycle: all outputs are registered, and out_valid rises the cycle after the triggering pixel is accepted.
REQ-025 out_sof SHALL be 1 only with the window at (x=2, y=2).
REQ-026 out_eol SHALL be 1 only with windows at x=IMG_WIDTH-1.
REQ-027 Idle cycles (in_valid=0) SHALL set out_valid=0, out_sof=0, out_eol=0 and SHALL hold w00..w22 unchanged.
REQ-028 Line-buffer contents left from a previous frame SHALL never appear in a window; this follows from the y>=2 rule.
REQ-029 Gaps of any length between pixels SHALL not change any produced window value.
REQ-030 Taps SHALL pass through unmodified: no arithmetic and no width change.

Reset
REQ-031 While reset=0 at a pclk edge, the block SHALL set x=0, y=0, and all column registers, w00..w22, out_valid, out_sof, out_eol, frame_done and sof_err to 0.
REQ-032 Line-buffer RAM contents SHALL not be cleared by reset.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; the first accepted pixel after release is position (0,0) whether or not in_sof is set.
REQ-034 in_valid during reset SHALL be ignored.

Verification
REQ-035 Using IMG_WIDTH=5, IMG_HEIGHT=4, in_data=y*16+x, one pixel per cycle:
- exactly 6 windows;
- first window has w00=0x00, w11=0x11, w22=0x22, with out_sof=1;
- out_eol is set on windows whose w22 is 0x24 or 0x34.
REQ-036 Same frame with in_valid toggling 1,0,1,0: identical window sequence to REQ-035, with out_valid never on the cycle after an idle cycle.
REQ-037 Two back-to-back frames, the second with in_data+0x80:
- frame_done pulses once per frame;
- the second frame's first window has w00=0x80.
REQ-038 in_sof injected at (3,2) of a 5x4 frame:
- sof_err pulses once;
- the next emitted window is at new (2,2) with out_sof=1.
REQ-039 reset=0 for 1 cycle at (2,3), then restart without in_sof:
- all outputs are 0 during reset;
- the first window afterwards is centre (1,1) of the new frame.
REQ-040 IMG_WIDTH=3, IMG_HEIGHT=3, DATA_WIDTH=12:
- a single window with out_sof=1 and out_eol=1 together;
- frame_done pulses 1 cycle later relative to the last pixel.
